voice_sched: RTL and testbench

//  Voice allocator and per-sample scheduler for the shared note_gen datapath.
//  - Takes note-on/note-off events and assigns each note to one of NUM_CHANNELS voices.
//  - On each sample tick, steps note_gen through every channel: curr_note, tuning_word, acc_en.
//  - Sums the returned per-channel waveforms into one mixed sample.

---
 rtl/voice_sched_pkg.sv | 12 +
 rtl/voice_table.sv | 70 +++++++
 rtl/voice_sched.sv | 100 ++++++++++
 tb/tb_voice_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/voice_sched_pkg.sv
// voice_sched_pkg: shared sizes and sweep FSM encoding for the voice scheduler.
package voice_sched_pkg;
  localparam int NUM_CHANNELS = 16;
  localparam int NUM_BITS = 32;
  localparam int WIDTH = 18;
  localparam int NOTE_BITS = 7;
  localparam int WAVE_LAT = 2;
  localparam int CH_BITS = $clog2(NUM_CHANNELS);
  localparam int MIX_BITS = WIDTH + CH_BITS;
  localparam logic [NUM_CHANNELS-1:0] CH_ONE = NUM_CHANNELS'(1);
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;
endpackage

// File: rtl/voice_table.sv
// voice_table: per-channel note/tuning storage with retrigger, free-slot and oldest-voice search.
module voice_table
  import voice_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ev_accept,
  input  logic                    ev_on,
  input  logic [NOTE_BITS-1:0]    ev_note,
  input  logic [NUM_BITS-1:0]     ev_tw,
  input  logic [CH_BITS-1:0]      rd_ch,
  output logic [NUM_BITS-1:0]     rd_tw,
  output logic [NUM_CHANNELS-1:0] active,
  output logic [CH_BITS-1:0]      on_ch
);
  logic [NUM_CHANNELS-1:0] active_q, active_d;
  logic [NOTE_BITS-1:0] note_q [NUM_CHANNELS];
  logic [NOTE_BITS-1:0] note_d [NUM_CHANNELS];
  logic [NUM_BITS-1:0] tw_q [NUM_CHANNELS];
  logic [NUM_BITS-1:0] tw_d [NUM_CHANNELS];
  logic [CH_BITS-1:0] age_q [NUM_CHANNELS];
  logic [CH_BITS-1:0] age_d [NUM_CHANNELS];
  logic hit, free;
  logic [CH_BITS-1:0] hit_ch, free_ch, old_ch, old_age;
  // Scan high to low so the lowest index wins every search, including age ties.
  always_comb begin
    hit = 1'b0;
    free = 1'b0;
    hit_ch = '0;
    free_ch = '0;
    old_ch = '0;
    old_age = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (active_q[i] && note_q[i] == ev_note) begin hit = 1'b1; hit_ch = CH_BITS'(i); end
      if (!active_q[i]) begin free = 1'b1; free_ch = CH_BITS'(i); end
      if (age_q[i] >= old_age) begin old_age = age_q[i]; old_ch = CH_BITS'(i); end
    end
    on_ch = hit ? hit_ch : free ? free_ch : old_ch;
  end
  always_comb begin
    active_d = active_q;
    note_d = note_q;
    tw_d = tw_q;
    age_d = age_q;
    if (ev_accept && ev_on) begin
      for (int i = 0; i < NUM_CHANNELS; i++)
        if (active_q[i] && age_q[i] != CH_BITS'(NUM_CHANNELS - 1)) age_d[i] = age_q[i] + 1'b1;
      active_d[on_ch] = 1'b1;
      note_d[on_ch] = ev_note;
      tw_d[on_ch] = ev_tw;
      age_d[on_ch] = '0;
    end else if (ev_accept && hit) active_d[hit_ch] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      active_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        note_q[i] <= '0;
        tw_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      active_q <= active_d;
      note_q <= note_d;
      tw_q <= tw_d;
      age_q <= age_d;
    end
  assign rd_tw = tw_q[rd_ch];
  assign active = active_q;
endmodule

// File: rtl/voice_sched.sv
// voice_sched: note event allocation, per-tick note_gen channel sweep and waveform mixing.
module voice_sched
  import voice_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_tick,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_on,
  input  logic [NOTE_BITS-1:0]    ev_note,
  input  logic [NUM_BITS-1:0]     ev_tw,
  output logic [NUM_CHANNELS-1:0] acc_en,
  output logic [NUM_CHANNELS-1:0] acc_clr,
  output logic [NUM_CHANNELS-1:0] curr_note,
  output logic [NUM_BITS-1:0]     tuning_word,
  input  logic [WIDTH-1:0]        wave_in,
  output logic [MIX_BITS-1:0]     mix_out,
  output logic                    mix_valid,
  output logic [NUM_CHANNELS-1:0] voices_active,
  output logic                    tick_overrun
);
  state_e state_q, state_d;
  logic [CH_BITS-1:0] ch_q, ch_d, on_ch;
  logic [MIX_BITS-1:0] acc_q, acc_d, mix_out_q, mix_out_d;
  logic mix_valid_q, mix_valid_d, overrun_q, overrun_d, accept;
  logic [WAVE_LAT-1:0] vld_q, vld_d, act_q, act_d;
  logic [NUM_CHANNELS-1:0] curr_note_q, curr_note_d, acc_en_q, acc_en_d, acc_clr_q, acc_clr_d;
  logic [NUM_BITS-1:0] tw_q, tw_d, rd_tw;
  assign ev_ready = state_q == IDLE && !sample_tick;
  assign accept = ev_valid && ev_ready;
  voice_table u_table (
    .clk(clk), .rst(rst), .ev_accept(accept), .ev_on(ev_on), .ev_note(ev_note), .ev_tw(ev_tw),
    .rd_ch(ch_d), .rd_tw(rd_tw), .active(voices_active), .on_ch(on_ch)
  );
  // ch_q doubles as the drain counter once the sweep is over.
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    acc_d = acc_q;
    mix_out_d = mix_out_q;
    mix_valid_d = 1'b0;
    overrun_d = overrun_q | (sample_tick && state_q != IDLE);
    vld_d = (vld_q << 1) | WAVE_LAT'(|curr_note_q);
    act_d = (act_q << 1) | WAVE_LAT'(|acc_en_q);
    if (vld_q[WAVE_LAT-1] && act_q[WAVE_LAT-1]) acc_d = acc_q + {{CH_BITS{wave_in[WIDTH-1]}}, wave_in};
    case (state_q)
      IDLE: if (sample_tick) begin state_d = SWEEP; ch_d = '0; acc_d = '0; end
      SWEEP: begin
        state_d = ch_q == CH_BITS'(NUM_CHANNELS - 1) ? DRAIN : SWEEP;
        ch_d = ch_q == CH_BITS'(NUM_CHANNELS - 1) ? '0 : ch_q + 1'b1;
      end
      DRAIN: begin
        state_d = ch_q == CH_BITS'(WAVE_LAT - 1) ? DONE : DRAIN;
        ch_d = ch_q + 1'b1;
      end
      DONE: begin state_d = IDLE; mix_out_d = acc_q; mix_valid_d = 1'b1; end
      default: state_d = IDLE;
    endcase
    curr_note_d = state_d == SWEEP ? CH_ONE << ch_d : '0;
    acc_en_d = curr_note_d & voices_active;
    tw_d = state_d == SWEEP ? rd_tw : '0;
    acc_clr_d = accept && ev_on ? CH_ONE << on_ch : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      ch_q <= '0;
      acc_q <= '0;
      mix_out_q <= '0;
      mix_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      vld_q <= '0;
      act_q <= '0;
      curr_note_q <= '0;
      acc_en_q <= '0;
      acc_clr_q <= '0;
      tw_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      acc_q <= acc_d;
      mix_out_q <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      overrun_q <= overrun_d;
      vld_q <= vld_d;
      act_q <= act_d;
      curr_note_q <= curr_note_d;
      acc_en_q <= acc_en_d;
      acc_clr_q <= acc_clr_d;
      tw_q <= tw_d;
    end
  assign curr_note = curr_note_q;
  assign acc_en = acc_en_q;
  assign acc_clr = acc_clr_q;
  assign tuning_word = tw_q;
  assign mix_out = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign tick_overrun = overrun_q;
endmodule

// File: tb/tb_voice_sched.sv
// tb_voice_sched: directed scenarios for allocation, sweep timing, mixing, overrun and reset.
module tb_voice_sched;
  import voice_sched_pkg::*;
  logic clk = 0, rst = 0, sample_tick = 0, ev_valid = 0, ev_on = 0;
  logic [NOTE_BITS-1:0] ev_note = '0;
  logic [NUM_BITS-1:0] ev_tw = '0;
  logic [WIDTH-1:0] wave_in = '0;
  logic ev_ready, mix_valid, tick_overrun;
  logic [NUM_CHANNELS-1:0] acc_en, acc_clr, curr_note, voices_active;
  logic [NUM_BITS-1:0] tuning_word;
  logic [MIX_BITS-1:0] mix_out;
  int checks = 0, failures = 0;
  int lat;
  logic [MIX_BITS-1:0] mix;
  logic [NUM_CHANNELS-1:0] en_log [40];
  logic [NUM_CHANNELS-1:0] cn_log [40];
  logic [NUM_BITS-1:0] tw_log [40];
  logic [NUM_CHANNELS-1:0] clr0, clr1;

  voice_sched dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_tw(ev_tw), .acc_en(acc_en), .acc_clr(acc_clr),
    .curr_note(curr_note), .tuning_word(tuning_word), .wave_in(wave_in), .mix_out(mix_out),
    .mix_valid(mix_valid), .voices_active(voices_active), .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  task automatic run_sweep();
    @(negedge clk);
    sample_tick = 1;
    @(posedge clk);
    #1 sample_tick = 0;
    lat = -1;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      @(negedge clk);
      en_log[n] = acc_en;
      cn_log[n] = curr_note;
      tw_log[n] = tuning_word;
      if (mix_valid) begin lat = n; mix = mix_out; end
    end
    checks++;
    if (lat < 0) begin failures++; $display("FAIL sweep_timeout: mix_valid never seen"); end
  endtask

  task automatic send_ev(input logic on, input logic [NOTE_BITS-1:0] note, input logic [NUM_BITS-1:0] tw);
    int n;
    @(negedge clk);
    ev_valid = 1; ev_on = on; ev_note = note; ev_tw = tw;
    n = 0;
    while (!ev_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!ev_ready) begin failures++; $display("FAIL ev_timeout: ev_ready stayed 0"); end
    @(posedge clk);
    #1 ev_valid = 0;
    clr0 = acc_clr;
    @(posedge clk);
    #1 clr1 = acc_clr;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({acc_en, acc_clr, curr_note, voices_active, mix_valid, tick_overrun} !== '0 || mix_out !== '0 || tuning_word !== '0) begin
      failures++; $display("FAIL reset_outputs: some output nonzero during reset");
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if (ev_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ev_ready); end
    run_sweep();
    checks++;
    if (lat !== NUM_CHANNELS + WAVE_LAT + 1) begin failures++; $display("FAIL empty_latency: got %0d want %0d", lat, NUM_CHANNELS + WAVE_LAT + 1); end
    checks++;
    if (mix !== '0) begin failures++; $display("FAIL empty_mix: got %0h want 0", mix); end
    for (int n = 0; n < 20; n++) begin
      checks++;
      if (en_log[n] !== '0) begin failures++; $display("FAIL empty_acc_en: cycle %0d got %h want 0", n, en_log[n]); end
    end
  endtask

  task automatic test_note_on();
    send_ev(1, 60, 32'h0100_0000);
    checks++;
    if (clr0 !== 16'h0001) begin failures++; $display("FAIL on_acc_clr: got %h want 0001", clr0); end
    checks++;
    if (clr1 !== 16'h0000) begin failures++; $display("FAIL on_acc_clr_pulse: got %h want 0000", clr1); end
    checks++;
    if (voices_active !== 16'h0001) begin failures++; $display("FAIL on_mask: got %h want 0001", voices_active); end
    run_sweep();
    checks++;
    if (en_log[0] !== 16'h0001) begin failures++; $display("FAIL sweep_en0: got %h want 0001", en_log[0]); end
    checks++;
    if (tw_log[0] !== 32'h0100_0000) begin failures++; $display("FAIL sweep_tw0: got %h want 01000000", tw_log[0]); end
    checks++;
    if (cn_log[3] !== 16'h0008) begin failures++; $display("FAIL sweep_curr3: got %h want 0008", cn_log[3]); end
    checks++;
    if (cn_log[16] !== 16'h0000) begin failures++; $display("FAIL sweep_curr_drain: got %h want 0000", cn_log[16]); end
    for (int n = 1; n < 16; n++) begin
      checks++;
      if (en_log[n] !== '0) begin failures++; $display("FAIL sweep_en: cycle %0d got %h want 0", n, en_log[n]); end
    end
  endtask

  task automatic test_mix();
    send_ev(1, 61, 32'h0200_0000);
    send_ev(1, 62, 32'h0300_0000);
    wave_in = 18'd100;
    run_sweep();
    checks++;
    if (mix !== MIX_BITS'(300)) begin failures++; $display("FAIL mix_300: got %0d want 300", mix); end
    wave_in = 18'(-5);
    run_sweep();
    checks++;
    if (mix !== MIX_BITS'(-15)) begin failures++; $display("FAIL mix_neg: got %h want %h", mix, MIX_BITS'(-15)); end
    for (int i = 63; i <= 75; i++) send_ev(1, NOTE_BITS'(i), NUM_BITS'(i));
    checks++;
    if (voices_active !== 16'hFFFF) begin failures++; $display("FAIL mix_full_mask: got %h want ffff", voices_active); end
    wave_in = 18'h1FFFF;
    run_sweep();
    checks++;
    if (mix !== MIX_BITS'(2097136)) begin failures++; $display("FAIL mix_max: got %0d want 2097136", mix); end
  endtask

  task automatic test_steal();
    send_ev(1, 80, 32'h1234_5678);
    checks++;
    if (clr0 !== 16'h0001) begin failures++; $display("FAIL steal_oldest: got %h want 0001", clr0); end
    send_ev(1, 61, 32'h0200_0000);
    checks++;
    if (clr0 !== 16'h0002) begin failures++; $display("FAIL retrigger: got %h want 0002", clr0); end
    send_ev(1, 90, 32'h0000_0090);
    checks++;
    if (clr0 !== 16'h0004) begin failures++; $display("FAIL steal_aged: got %h want 0004", clr0); end
    send_ev(0, 100, 32'h0);
    checks++;
    if (voices_active !== 16'hFFFF || clr0 !== 16'h0000) begin
      failures++; $display("FAIL off_unknown: mask %h clr %h want ffff 0000", voices_active, clr0);
    end
    send_ev(0, 61, 32'h0);
    checks++;
    if (voices_active !== 16'hFFFD) begin failures++; $display("FAIL off_known: got %h want fffd", voices_active); end
    send_ev(1, 99, 32'h0000_0099);
    checks++;
    if (clr0 !== 16'h0002 || voices_active !== 16'hFFFF) begin
      failures++; $display("FAIL lowest_free: clr %h mask %h want 0002 ffff", clr0, voices_active);
    end
  endtask

  task automatic test_tick_priority();
    int n;
    int seen;
    @(negedge clk);
    sample_tick = 1; ev_valid = 1; ev_on = 0; ev_note = 99; ev_tw = '0;
    #1;
    checks++;
    if (ev_ready !== 1'b0) begin failures++; $display("FAIL tick_wins: ev_ready got %b want 0", ev_ready); end
    @(posedge clk);
    #1 sample_tick = 0;
    checks++;
    if (tick_overrun !== 1'b0) begin failures++; $display("FAIL overrun_early: got %b want 0", tick_overrun); end
    repeat (4) @(negedge clk);
    sample_tick = 1;
    @(posedge clk);
    #1 sample_tick = 0;
    checks++;
    if (tick_overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: got %b want 1", tick_overrun); end
    n = 0;
    while (!mix_valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!mix_valid) begin failures++; $display("FAIL prio_sweep_timeout: mix_valid never seen"); end
    checks++;
    if (voices_active !== 16'hFFFF) begin failures++; $display("FAIL table_frozen: got %h want ffff", voices_active); end
    @(posedge clk);
    #1 ev_valid = 0;
    checks++;
    if (voices_active !== 16'hFFFD) begin failures++; $display("FAIL event_after_done: got %h want fffd", voices_active); end
    seen = 0;
    repeat (25) begin @(negedge clk); if (mix_valid) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL dropped_tick: got %0d extra mix_valid want 0", seen); end
    checks++;
    if (tick_overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky: got %b want 1", tick_overrun); end
  endtask

  task automatic test_reset_mid_sweep();
    int seen;
    @(negedge clk);
    sample_tick = 1;
    @(posedge clk);
    #1 sample_tick = 0;
    repeat (6) @(negedge clk);
    checks++;
    if (curr_note !== 16'h0020) begin failures++; $display("FAIL mid_sweep_ch5: got %h want 0020", curr_note); end
    rst = 0;
    #1;
    checks++;
    if ({curr_note, acc_en, acc_clr, voices_active, mix_valid, tick_overrun} !== '0 || tuning_word !== '0 || mix_out !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: curr %h en %h mask %h ovr %b want 0", curr_note, acc_en, voices_active, tick_overrun);
    end
    @(negedge clk);
    rst = 1;
    seen = 0;
    repeat (30) begin @(negedge clk); if (mix_valid) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL mid_reset_mix: got %0d mix_valid want 0", seen); end
    checks++;
    if (ev_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_idle: ev_ready got %b want 1", ev_ready); end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_mix();
    test_steal();
    test_tick_priority();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
